// File: rtl/firbank_arbiter.sv
// Round-robin, burst-locking arbiter that shares one synchronous-read FIR coefficient ROM.
// Optional macro FIRBANK_ARB_BURST_LIMIT_EN adds MAX_BURST preemption of long locked bursts.
module firbank_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int NUM_REQ_LOG2 = 1,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 24,
    parameter int ROM_LATENCY  = 1
`ifdef FIRBANK_ARB_BURST_LIMIT_EN
    ,
    parameter int MAX_BURST    = 64
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [ADDR_W-1:0]         bank_addr_o,
    input  logic [DATA_W-1:0]         bank_data_i,
    output logic [DATA_W-1:0]         data_o,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      busy_o
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam int         IW       = NUM_REQ_LOG2;

    logic [0:0]                          r_state;
    logic [IW-1:0]                       r_ptr;
    logic [IW-1:0]                       r_owner;
    logic [NUM_REQ-1:0]                  r_gnt;
    logic [ADDR_W-1:0]                   r_bank_addr;
    logic [ROM_LATENCY:0][NUM_REQ-1:0]   r_tag;

    logic                                w_found;
    logic [IW-1:0]                       w_winner;
    logic [IW:0]                         w_cand;
    logic                                w_accept;
    logic                                w_release;
    logic                                w_preempt;
    logic [ADDR_W-1:0]                   w_owner_addr;

    // Search starts at the pointer and wraps modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IW+1)'(NUM_REQ);
            end
            if (!w_found && req_i[w_cand[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IW-1:0];
            end
        end
    end

    assign w_accept     = (r_state == ST_GRANT) && req_i[r_owner];
    assign w_owner_addr = addr_i[int'(r_owner)*ADDR_W +: ADDR_W];

`ifdef FIRBANK_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] r_burst_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_burst_cnt;
        if (w_accept && (r_burst_cnt != CW'(MAX_BURST))) begin
            w_cnt_next = r_burst_cnt + CW'(1);
        end
    end

    // Preempt only when someone else is waiting; otherwise the count saturates.
    assign w_preempt = w_accept && (w_cnt_next == CW'(MAX_BURST)) && (|(req_i & ~r_gnt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= w_cnt_next;
        end
    end
`else
    assign w_preempt = 1'b0;
`endif

    assign w_release = (r_state == ST_GRANT) &&
                       (!req_i[r_owner] || (w_accept && (!lock_i[r_owner] || w_preempt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_gnt       <= '0;
            r_bank_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_winner;
                        r_gnt   <= NUM_REQ'(1) << w_winner;
                        r_ptr   <= (w_winner == IW'(NUM_REQ - 1)) ? '0 : w_winner + IW'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_bank_addr <= w_owner_addr;
                    end
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Owner tag rides alongside the ROM read so the ack lands with its data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= w_accept ? r_gnt : '0;
            for (int i = 1; i <= ROM_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign gnt_o       = r_gnt;
    assign bank_addr_o = r_bank_addr;
    assign data_o      = bank_data_i;
    assign ack_o       = r_tag[ROM_LATENCY];
    assign busy_o      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_firbank_arbiter.sv
// Scoreboard bench for firbank_arbiter: directed scenarios plus random traffic against a reference model.
module tb_firbank_arbiter;
    localparam int NR   = 2;
    localparam int AW   = 12;
    localparam int DW   = 24;
    localparam int RL   = 1;
    localparam int MAXB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NR-1:0]  req = '0;
    logic [NR-1:0]  lock = '0;
    logic [NR*AW-1:0] addr = '0;
    logic [NR-1:0]  gnt_o;
    logic [AW-1:0]  bank_addr_o;
    logic [DW-1:0]  rom_q = '0;
    logic [DW-1:0]  data_o;
    logic [NR-1:0]  ack_o;
    logic           busy_o;

    logic [DW-1:0]  rom [0:(1<<AW)-1];

    typedef struct {
        int          owner;
        logic [DW-1:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit             m_busy = 1'b0;
    int             m_owner = 0;
    int             m_ptr = 0;
    int             m_cnt = 0;
    int             k = 0;
    bit             m_last = 1'b0;
    logic [NR-1:0]  exp_gnt = '0;
    logic [AW-1:0]  exp_baddr = '0;
    exp_t           push_e;
    exp_t           pop_e;

    firbank_arbiter #(
        .NUM_REQ(NR),
        .NUM_REQ_LOG2(1),
        .ADDR_W(AW),
        .DATA_W(DW),
        .ROM_LATENCY(RL)
`ifdef FIRBANK_ARB_BURST_LIMIT_EN
        ,
        .MAX_BURST(MAXB)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_i(req),
        .lock_i(lock),
        .addr_i(addr),
        .gnt_o(gnt_o),
        .bank_addr_o(bank_addr_o),
        .bank_data_i(rom_q),
        .data_o(data_o),
        .ack_o(ack_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            rom[i] = DW'((i * 32'd40503) ^ 32'h005A5A5A);
        end
    end

    // One-cycle synchronous-read ROM
    always @(posedge clk) rom_q <= rom[bank_addr_o];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: owner/pointer as integers, expected responses pushed on each accepted access.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy    = 1'b0;
            m_owner   = 0;
            m_ptr     = 0;
            m_cnt     = 0;
            exp_gnt   = '0;
            exp_baddr = '0;
            sb.delete();
        end else begin
            cyc++;
            if (!m_busy) begin
                for (int i = 0; i < NR; i++) begin
                    k = (m_ptr + i) % NR;
                    if (!m_busy && req[k]) begin
                        m_busy  = 1'b1;
                        m_owner = k;
                        m_ptr   = (k + 1) % NR;
                        m_cnt   = 0;
                    end
                end
                exp_gnt = m_busy ? NR'(1 << m_owner) : '0;
            end else if (!req[m_owner]) begin
                m_busy  = 1'b0;
                exp_gnt = '0;
            end else begin
                exp_baddr    = addr[m_owner*AW +: AW];
                push_e.owner = m_owner;
                push_e.data  = rom[exp_baddr];
                push_e.due   = cyc + RL;
                sb.push_back(push_e);
                m_last = !lock[m_owner];
`ifdef FIRBANK_ARB_BURST_LIMIT_EN
                if (m_cnt < MAXB) m_cnt++;
                if (m_cnt == MAXB && ((req & ~NR'(1 << m_owner)) != '0)) m_last = 1'b1;
`endif
                if (m_last) begin
                    m_busy  = 1'b0;
                    exp_gnt = '0;
                end
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard whenever an ack appears.
    initial forever begin
        @(negedge clk);
        chk("gnt", 64'(gnt_o), 64'(exp_gnt));
        chk("busy", 64'(busy_o), 64'(m_busy));
        chk("bank_addr", 64'(bank_addr_o), 64'(exp_baddr));
        if (ack_o !== '0) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 64'(ack_o), 64'(0));
            end else begin
                pop_e = sb.pop_front();
                chk("ack_onehot", 64'(ack_o), 64'(1 << pop_e.owner));
                chk("ack_data", 64'(data_o), 64'(pop_e.data));
                chk("ack_cycle", 64'(cyc), 64'(pop_e.due));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            pop_e = sb.pop_front();
            chk("missing_ack", 64'(ack_o), 64'(1 << pop_e.owner));
        end
    end

    task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] l,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(posedge clk);
        #1;
        req  = r;
        lock = l;
        addr = {a1, a0};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 12'h000, 12'h000);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Single request
        drive(2'b01, 2'b00, 12'h123, 12'h000);
        drive(2'b01, 2'b00, 12'h123, 12'h000);
        idle(4);

        // Contention, round-robin
        for (int i = 0; i < 12; i++) drive(2'b11, 2'b00, 12'(16 + i), 12'(32 + i));
        idle(4);

        // Burst lock by requester 1 while requester 0 waits
        drive(2'b10, 2'b10, 12'h000, 12'h000);
        for (int i = 0; i < 8; i++) drive(2'b11, {(i < 7), 1'b0}, 12'h3A0, 12'(i));
        for (int i = 0; i < 3; i++) drive(2'b01, 2'b00, 12'h3B0, 12'h000);
        idle(4);

        // Abandon after two accepted beats
        drive(2'b01, 2'b01, 12'h050, 12'h000);
        drive(2'b01, 2'b01, 12'h051, 12'h000);
        drive(2'b01, 2'b01, 12'h052, 12'h000);
        idle(5);

        // Reset while acks are in flight
        drive(2'b01, 2'b01, 12'h070, 12'h000);
        drive(2'b01, 2'b01, 12'h071, 12'h000);
        drive(2'b01, 2'b01, 12'h072, 12'h000);
        do_reset(2);
        drive(2'b11, 2'b00, 12'h080, 12'h090);
        drive(2'b11, 2'b00, 12'h081, 12'h091);
        idle(4);

`ifdef FIRBANK_ARB_BURST_LIMIT_EN
        // Requester 0 locked indefinitely, requester 1 pending
        drive(2'b01, 2'b01, 12'h100, 12'h200);
        for (int i = 0; i < 24; i++) drive(2'b11, 2'b11, 12'(12'h101 + i), 12'(12'h201 + i));
        idle(4);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(NR'($urandom_range(0, 3)),
                  {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                  AW'($urandom), AW'($urandom));
        end
        idle(6);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
